// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU with registered forwarding of decode controls.
// Latency: 1 cycle for all ops; MUL (EXECUTE_STAGE_MUL_EN) takes WIDTH+1 edges.
// Backpressure: combinational stall asks upstream to hold inputs during a MUL.
//
// Ports:
//   clk, reset              - single clock, synchronous active-high reset
//   pcWe..regWe             - decode-stage write enables, forwarded to *Out
//   op1, op2, dataToWrite   - operands and store data (WIDTH bits)
//   regToWrite, aluMode     - destination register and operation select
//   aluResult, flags        - registered result and {N,Z,C,V}
//   stall                   - combinational hold request to the decode stage
//
// Build option: define EXECUTE_STAGE_MUL_EN to include the iterative
// shift-add multiplier and its IDLE/BUSY FSM. Without it, MUL yields 0.
module execute_stage #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcWe,
  input  logic             memWe,
  input  logic             flagsWe,
  input  logic             writeRegFromAlu,
  input  logic             regWe,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] dataToWrite,
  input  logic [3:0]       regToWrite,
  input  logic [2:0]       aluMode,
  output logic             pcWeOut,
  output logic             memWeOut,
  output logic             writeRegFromAluOut,
  output logic             regWeOut,
  output logic [WIDTH-1:0] aluResult,
  output logic [WIDTH-1:0] dataToWriteOut,
  output logic [3:0]       regToWriteOut,
  output logic [3:0]       flags,
  output logic             stall
);

  localparam logic [2:0]  OP_ADD = 3'b000;
  localparam logic [2:0]  OP_SUB = 3'b001;
  localparam logic [2:0]  OP_MUL = 3'b010;
  localparam logic [2:0]  OP_AND = 3'b011;
  localparam logic [2:0]  OP_OR  = 3'b100;
  localparam logic [2:0]  OP_XOR = 3'b101;
  localparam logic [2:0]  OP_SHL = 3'b110;
  localparam logic [2:0]  OP_SHR = 3'b111;

  localparam logic [31:0] WIDTH_U = 32'(WIDTH);

  // ---------------------------------------------------------------------
  // Combinational ALU (all ops except the iterative multiply)
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   add_ext;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] shl_res;
  logic [WIDTH-1:0] shr_res;
  logic [31:0]      shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  always_comb begin
    add_ext = {1'b0, op1} + {1'b0, op2};
    sub_res = op1 - op2;
    shamt   = {27'd0, op2[4:0]};
    // Shift amounts at or beyond the datapath width flush to zero.
    shl_res = (shamt >= WIDTH_U) ? '0 : (op1 << op2[4:0]);
    shr_res = (shamt >= WIDTH_U) ? '0 : (op1 >> op2[4:0]);

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (aluMode)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                  (add_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_c   = (op1 >= op2);  // carry means "no borrow"
        alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                  (sub_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_MUL: alu_res = '0;      // product comes from the multiplier path
      OP_AND: alu_res = op1 & op2;
      OP_OR:  alu_res = op1 | op2;
      OP_XOR: alu_res = op1 ^ op2;
      OP_SHL: alu_res = shl_res;
      OP_SHR: alu_res = shr_res;
      default: alu_res = '0;
    endcase
    alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
  end

  // ---------------------------------------------------------------------
  // Output pipeline registers
  // ---------------------------------------------------------------------
  logic             pc_we_q,    pc_we_d;
  logic             mem_we_q,   mem_we_d;
  logic             wr_alu_q,   wr_alu_d;
  logic             reg_we_q,   reg_we_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic [WIDTH-1:0] data_q,     data_d;
  logic [3:0]       reg_dst_q,  reg_dst_d;
  logic [3:0]       flags_q,    flags_d;

  // Values that would load this edge unless a bubble is inserted.
  logic             ld_pc_we, ld_mem_we, ld_wr_alu, ld_reg_we, ld_flags_we;
  logic [WIDTH-1:0] ld_result, ld_data;
  logic [3:0]       ld_reg_dst, ld_flags;
  logic             bubble;

`ifdef EXECUTE_STAGE_MUL_EN
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  logic [0:0]       state_q,    state_d;
  logic [4:0]       cnt_q,      cnt_d;
  logic [WIDTH-1:0] mcand_q,    mcand_d;
  logic [WIDTH-1:0] mplier_q,   mplier_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  // Controls captured at MUL start; released with the product.
  logic             h_pc_we_q,    h_pc_we_d;
  logic             h_mem_we_q,   h_mem_we_d;
  logic             h_flags_we_q, h_flags_we_d;
  logic             h_wr_alu_q,   h_wr_alu_d;
  logic             h_reg_we_q,   h_reg_we_d;
  logic [3:0]       h_reg_dst_q,  h_reg_dst_d;
  logic [WIDTH-1:0] h_data_q,     h_data_d;
  logic             mul_start;
  logic             stall_c;
`endif

  always_comb begin
    ld_pc_we    = pcWe;
    ld_mem_we   = memWe;
    ld_wr_alu   = writeRegFromAlu;
    ld_reg_we   = regWe;
    ld_flags_we = flagsWe;
    ld_result   = alu_res;
    ld_data     = dataToWrite;
    ld_reg_dst  = regToWrite;
    ld_flags    = alu_flags;
    bubble      = 1'b0;

`ifdef EXECUTE_STAGE_MUL_EN
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    h_pc_we_d    = h_pc_we_q;
    h_mem_we_d   = h_mem_we_q;
    h_flags_we_d = h_flags_we_q;
    h_wr_alu_d   = h_wr_alu_q;
    h_reg_we_d   = h_reg_we_q;
    h_reg_dst_d  = h_reg_dst_q;
    h_data_d     = h_data_q;
    stall_c      = 1'b0;
    // A MUL that writes nothing is not worth the stall; it degrades to a bubble.
    mul_start    = (aluMode == OP_MUL) && (regWe || flagsWe);

    if (state_q == IDLE) begin
      if (aluMode == OP_MUL) begin
        bubble = 1'b1;
        if (mul_start) begin
          stall_c      = 1'b1;
          state_d      = BUSY;
          cnt_d        = '0;
          mcand_d      = op1;
          mplier_d     = op2;
          acc_d        = '0;
          h_pc_we_d    = pcWe;
          h_mem_we_d   = memWe;
          h_flags_we_d = flagsWe;
          h_wr_alu_d   = writeRegFromAlu;
          h_reg_we_d   = regWe;
          h_reg_dst_d  = regToWrite;
          h_data_d     = dataToWrite;
        end
      end
    end else begin
      // One shift-add step: multiplier bit cnt_q is at mplier_q[0].
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == LAST_STEP) begin
        // Final step: stall drops so upstream consumes the MUL on this edge.
        state_d     = IDLE;
        cnt_d       = '0;
        ld_pc_we    = h_pc_we_q;
        ld_mem_we   = h_mem_we_q;
        ld_wr_alu   = h_wr_alu_q;
        ld_reg_we   = h_reg_we_q;
        ld_flags_we = h_flags_we_q;
        ld_result   = acc_d;
        ld_data     = h_data_q;
        ld_reg_dst  = h_reg_dst_q;
        ld_flags    = {acc_d[WIDTH-1], (acc_d == '0), 2'b00};
      end else begin
        stall_c = 1'b1;
        bubble  = 1'b1;
      end
    end
`endif

    if (bubble) begin
      pc_we_d   = 1'b0;
      mem_we_d  = 1'b0;
      wr_alu_d  = 1'b0;
      reg_we_d  = 1'b0;
      result_d  = '0;
      data_d    = '0;
      reg_dst_d = '0;
      flags_d   = flags_q;
    end else begin
      pc_we_d   = ld_pc_we;
      mem_we_d  = ld_mem_we;
      wr_alu_d  = ld_wr_alu;
      reg_we_d  = ld_reg_we;
      result_d  = ld_result;
      data_d    = ld_data;
      reg_dst_d = ld_reg_dst;
      flags_d   = ld_flags_we ? ld_flags : flags_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_we_q   <= 1'b0;
      mem_we_q  <= 1'b0;
      wr_alu_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      result_q  <= '0;
      data_q    <= '0;
      reg_dst_q <= '0;
      flags_q   <= '0;
    end else begin
      pc_we_q   <= pc_we_d;
      mem_we_q  <= mem_we_d;
      wr_alu_q  <= wr_alu_d;
      reg_we_q  <= reg_we_d;
      result_q  <= result_d;
      data_q    <= data_d;
      reg_dst_q <= reg_dst_d;
      flags_q   <= flags_d;
    end
  end

`ifdef EXECUTE_STAGE_MUL_EN
  // Reset mid-multiply simply drops the operation; nothing is written back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      h_pc_we_q    <= 1'b0;
      h_mem_we_q   <= 1'b0;
      h_flags_we_q <= 1'b0;
      h_wr_alu_q   <= 1'b0;
      h_reg_we_q   <= 1'b0;
      h_reg_dst_q  <= '0;
      h_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      h_pc_we_q    <= h_pc_we_d;
      h_mem_we_q   <= h_mem_we_d;
      h_flags_we_q <= h_flags_we_d;
      h_wr_alu_q   <= h_wr_alu_d;
      h_reg_we_q   <= h_reg_we_d;
      h_reg_dst_q  <= h_reg_dst_d;
      h_data_q     <= h_data_d;
    end
  end

  assign stall = stall_c;
`else
  assign stall = 1'b0;
`endif

  assign pcWeOut            = pc_we_q;
  assign memWeOut           = mem_we_q;
  assign writeRegFromAluOut = wr_alu_q;
  assign regWeOut           = reg_we_q;
  assign aluResult          = result_q;
  assign dataToWriteOut     = data_q;
  assign regToWriteOut      = reg_dst_q;
  assign flags              = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  localparam int     W    = 24;
  localparam longint FULL = longint'(1) << W;
  localparam longint HALF = longint'(1) << (W - 1);
  localparam longint MASK = FULL - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         pcWe, memWe, flagsWe, writeRegFromAlu, regWe;
  logic [W-1:0] op1, op2, dataToWrite;
  logic [3:0]   regToWrite;
  logic [2:0]   aluMode;
  logic         pcWeOut, memWeOut, writeRegFromAluOut, regWeOut;
  logic [W-1:0] aluResult, dataToWriteOut;
  logic [3:0]   regToWriteOut;
  logic [3:0]   flags;
  logic         stall;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_flags;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .pcWe(pcWe), .memWe(memWe), .flagsWe(flagsWe),
    .writeRegFromAlu(writeRegFromAlu), .regWe(regWe),
    .op1(op1), .op2(op2), .dataToWrite(dataToWrite),
    .regToWrite(regToWrite), .aluMode(aluMode),
    .pcWeOut(pcWeOut), .memWeOut(memWeOut),
    .writeRegFromAluOut(writeRegFromAluOut), .regWeOut(regWeOut),
    .aluResult(aluResult), .dataToWriteOut(dataToWriteOut),
    .regToWriteOut(regToWriteOut), .flags(flags), .stall(stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU: plain integer arithmetic on the operands' numeric values.
  function automatic void model_alu(input logic [2:0] mode, input longint a, input longint b,
                                    output longint res, output logic [3:0] f);
    longint sa, sb, sr;
    int     amt;
    logic   c, v;
    c   = 1'b0;
    v   = 1'b0;
    sa  = (a >= HALF) ? a - FULL : a;
    sb  = (b >= HALF) ? b - FULL : b;
    amt = int'(b & 31);
    res = 0;
    case (mode)
      3'd0: begin res = (a + b) & MASK; c = ((a + b) >= FULL); sr = sa + sb; v = (sr >= HALF) || (sr < -HALF); end
      3'd1: begin res = (a - b) & MASK; c = (a >= b);          sr = sa - sb; v = (sr >= HALF) || (sr < -HALF); end
`ifdef EXECUTE_STAGE_MUL_EN
      3'd2: res = (a * b) & MASK;
`else
      3'd2: res = 0;
`endif
      3'd3: res = a & b;
      3'd4: res = a | b;
      3'd5: res = a ^ b;
      3'd6: res = (amt >= W) ? 0 : ((a << amt) & MASK);
      default: res = (amt >= W) ? 0 : (a >> amt);
    endcase
    f = {res[W-1], (res == 0), c, v};
  endfunction

  task automatic drive(input logic [2:0] mode, input longint a, input longint b,
                       input logic fwe, input logic rwe, input logic pcw, input logic mw,
                       input logic wra, input logic [3:0] rdst, input longint data);
    aluMode = mode; op1 = a[W-1:0]; op2 = b[W-1:0];
    flagsWe = fwe; regWe = rwe; pcWe = pcw; memWe = mw; writeRegFromAlu = wra;
    regToWrite = rdst; dataToWrite = data[W-1:0];
  endtask

  task automatic check_outputs(input logic pcw, input logic mw, input logic wra, input logic rwe,
                               input longint res, input logic [3:0] rdst, input longint data);
    check("pcWeOut",  pcWeOut, pcw);
    check("memWeOut", memWeOut, mw);
    check("wrAluOut", writeRegFromAluOut, wra);
    check("regWeOut", regWeOut, rwe);
    check("aluResult", aluResult, res);
    check("regToWriteOut", regToWriteOut, rdst);
    check("dataToWriteOut", dataToWriteOut, data);
    check("flags", flags, exp_flags);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_we"}, {pcWeOut, memWeOut, writeRegFromAluOut, regWeOut}, 4'b0000);
    check({tag, "_res"}, aluResult, 0);
    check({tag, "_flags"}, flags, exp_flags);
  endtask

  // Single-cycle op; entered and left at posedge+1.
  task automatic run_op(input logic [2:0] mode, input longint a, input longint b,
                        input logic fwe, input logic rwe, input logic pcw, input logic mw,
                        input logic wra, input logic [3:0] rdst, input longint data);
    longint     res;
    logic [3:0] f;
    logic       is_bubble;
    drive(mode, a, b, fwe, rwe, pcw, mw, wra, rdst, data);
    model_alu(mode, a, b, res, f);
    is_bubble = 1'b0;
`ifdef EXECUTE_STAGE_MUL_EN
    is_bubble = (mode == 3'd2) && !(fwe || rwe);
`endif
    #1 check("stall_1cyc", stall, 1'b0);
    @(posedge clk); #1;
    if (is_bubble) begin
      check_bubble("mulbub");
    end else begin
      if (fwe) exp_flags = f;
      check_outputs(pcw, mw, wra, rwe, res, rdst, data);
    end
  endtask

`ifdef EXECUTE_STAGE_MUL_EN
  // Multi-cycle MUL held by upstream for exactly as long as stall is high.
  task automatic run_mul(input longint a, input longint b, input logic fwe, input logic rwe,
                         input logic pcw, input logic mw, input logic wra,
                         input logic [3:0] rdst, input longint data, input logic scramble);
    longint     res;
    logic [3:0] f;
    model_alu(3'd2, a, b, res, f);
    drive(3'd2, a, b, fwe, rwe, pcw, mw, wra, rdst, data);
    for (int c = 0; c <= W; c++) begin
      #1 check("mul_stall", stall, (c < W));
      @(posedge clk); #1;
      if (c < W) begin
        check_bubble("mul_wait");
        // The operands latched at start must be used, whatever shows up later.
        if (scramble) begin
          op1 = W'($urandom);
          op2 = W'($urandom);
        end
      end else begin
        if (fwe) exp_flags = f;
        check_outputs(pcw, mw, wra, rwe, res, rdst, data);
      end
    end
  endtask
`endif

  function automatic longint rand_operand();
    case ($urandom % 6)
      0: return 0;
      1: return MASK;
      2: return HALF;
      3: return HALF - 1;
      default: return longint'($urandom) & MASK;
    endcase
  endfunction

  initial begin
    logic [2:0] mode;
    longint     a, b;
    logic       fwe, rwe;

    reset = 1'b1;
    drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    exp_flags = 4'b0000;
    check_outputs(0, 0, 0, 0, 0, 4'd0, 0);
    check("reset_stall", stall, 1'b0);
    reset = 1'b0;

    // Directed boundary cases.
    run_op(3'd0, 64'h7FFFFF, 1, 1, 0, 0, 0, 0, 4'd0, 0);
    check("add_ovf_res", aluResult, 24'h800000);
    check("add_ovf_flags", flags, 4'b1001);
    run_op(3'd1, 5, 5, 1, 1, 0, 0, 0, 4'd3, 0);
    check("sub_eq_res", aluResult, 0);
    check("sub_eq_flags", flags, 4'b0110);
    check("sub_eq_rdst", regToWriteOut, 4'd3);
    check("sub_eq_rwe", regWeOut, 1'b1);
    run_op(3'd6, 1, 24, 0, 0, 0, 0, 0, 4'd0, 0);
    check("shl24_res", aluResult, 0);
    check("shl24_flags_held", flags, 4'b0110);
    run_op(3'd7, 64'h800000, 23, 0, 0, 0, 0, 0, 4'd0, 0);
    check("shr23_res", aluResult, 1);
    check("shr23_flags_held", flags, 4'b0110);

`ifdef EXECUTE_STAGE_MUL_EN
    run_mul(1000, 3000, 0, 1, 0, 0, 1, 4'd7, 0, 0);
    check("mul_const", aluResult, 24'h2DC6C0);

    // Abort a MUL with reset during its 10th cycle.
    drive(3'd2, 1000, 3000, 0, 1, 0, 0, 0, 4'd5, 0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0);
    @(posedge clk); #1;
    exp_flags = 4'b0000;
    check_outputs(0, 0, 0, 0, 0, 4'd0, 0);
    check("abort_stall", stall, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < W + 4; i++) run_op(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0);
    run_mul(1000, 3000, 1, 1, 1, 1, 1, 4'd9, 64'h123456, 1);
`else
    run_op(3'd2, 1000, 3000, 1, 1, 0, 0, 1, 4'd7, 0);
    check("mul_off_res", aluResult, 0);
    check("mul_off_flags", flags, 4'b0100);
`endif

    // Randomized single-cycle traffic.
    for (int i = 0; i < 400; i++) begin
      mode = 3'($urandom);
      a    = rand_operand();
      b    = rand_operand();
      if (mode >= 3'd6 && ($urandom % 2) == 0) b = longint'($urandom_range(0, 31));
      fwe  = 1'($urandom);
      rwe  = 1'($urandom);
`ifdef EXECUTE_STAGE_MUL_EN
      if (mode == 3'd2) begin fwe = 1'b0; rwe = 1'b0; end
`endif
      run_op(mode, a, b, fwe, rwe, 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), longint'($urandom) & MASK);
    end

`ifdef EXECUTE_STAGE_MUL_EN
    for (int i = 0; i < 6; i++) begin
      fwe = 1'($urandom);
      rwe = !fwe || 1'($urandom);
      run_mul(rand_operand(), rand_operand(), fwe, rwe, 1'($urandom), 1'($urandom),
              1'($urandom), 4'($urandom), longint'($urandom) & MASK, 1'($urandom));
      run_op(3'd0, rand_operand(), rand_operand(), 1, 1, 0, 0, 1, 4'($urandom), 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
